// File: rtl/beat_seq_pkg.sv
// Shared definitions for the beat sequencer: FSM state encoding, tone codes, and the melody.
// The tone constants are the same codes the note generator decodes.
package beat_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int TONE_BITS = 5;
    typedef logic [TONE_BITS-1:0] tone_t;

    localparam tone_t TONE_REST = 5'd0;
    localparam tone_t C4 = 5'd1;
    localparam tone_t D4 = 5'd2;
    localparam tone_t E4 = 5'd3;
    localparam tone_t F4 = 5'd4;
    localparam tone_t G4 = 5'd5;
    localparam tone_t A4 = 5'd6;
    localparam tone_t B4 = 5'd7;
    localparam tone_t C5 = 5'd8;
    localparam tone_t D5 = 5'd9;
    localparam tone_t E5 = 5'd10;
    localparam tone_t F5 = 5'd11;
    localparam tone_t G5 = 5'd12;
    localparam tone_t A5 = 5'd13;
    localparam tone_t B5 = 5'd14;

    localparam int unsigned PHRASE_LEN = 16;

    // The melody repeats a 16-beat phrase, so any BEATS value maps onto it.
    function automatic tone_t melody_tone(input int unsigned idx);
        case (idx % PHRASE_LEN)
            0:       return C4;
            1:       return E4;
            2:       return G4;
            3:       return C5;
            4:       return B4;
            5:       return G4;
            6:       return E4;
            8:       return D4;
            9:       return F4;
            10:      return A4;
            11:      return D5;
            12:      return C5;
            13:      return A4;
            14:      return F4;
            default: return TONE_REST;
        endcase
    endfunction

endpackage

// File: rtl/beat_sequencer_if.sv
// Play-control inputs and tone outputs between the speed controller, the beat sequencer
// and the note generator.
interface beat_sequencer_if #(
    parameter int BEAT_W = 7,
    parameter int TONE_W = 5
);
    logic              play_clk;
    logic              play;
    logic              stop;
    logic [BEAT_W-1:0] beat;
    logic [TONE_W-1:0] tone_code;
    logic              note_valid;
    logic              done;

    modport master (
        output play_clk, play, stop,
        input  beat, tone_code, note_valid, done
    );

    modport slave (
        input  play_clk, play, stop,
        output beat, tone_code, note_valid, done
    );
endinterface

// File: rtl/melody_rom.sv
// Registered melody lookup: tone_code is the tone of the beat presented one clock earlier.
module melody_rom
    import beat_seq_pkg::*;
#(
    parameter int BEAT_W = 7,
    parameter int TONE_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BEAT_W-1:0] beat,
    output logic [TONE_W-1:0] tone_code
);

    // NOTE: the table itself is constant logic with nothing to reset; only the output
    // register is reset so tone_code reads 0 while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tone_code <= '0;
        else     tone_code <= TONE_W'(melody_tone(32'(beat)));
    end

endmodule

// File: rtl/beat_sequencer.sv
// Steps a beat index through the melody on each rising edge of play_clk and emits tone codes.
// Define SEQ_LOOP_EN to wrap the melody forever; otherwise it stops in DONE at the last beat.
module beat_sequencer
    import beat_seq_pkg::*;
#(
    parameter int BEATS  = 128,
    parameter int BEAT_W = $clog2(BEATS),
    parameter int TONE_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    beat_sequencer_if.slave   bus
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    seq_state_t        state, state_next;
    logic [BEAT_W-1:0] beat_q, beat_next;
    logic              play_clk_q;
    logic              note_valid_q;
    logic              tick;
    logic [TONE_W-1:0] tone_code;

    // play_clk is generated from clk, so a single register is enough for edge detection.
    assign tick = bus.play_clk & ~play_clk_q;

    // NOTE: registers update with non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            beat_q       <= '0;
            play_clk_q   <= 1'b0;
            note_valid_q <= 1'b0;
        end else begin
            state        <= state_next;
            beat_q       <= beat_next;
            play_clk_q   <= bus.play_clk;
            note_valid_q <= (state == PLAY);
        end
    end

    // NOTE: both outputs get their hold values first, so no path through the
    // case can leave them unassigned and infer a latch.
    always_comb begin
        state_next = state;
        beat_next  = beat_q;
        if (bus.stop) begin
            state_next = IDLE;
            beat_next  = '0;
        end else begin
            case (state)
                IDLE:  if (bus.play) state_next = PLAY;
                PLAY: begin
                    if (!bus.play) begin
                        state_next = PAUSE;
                    end else if (tick) begin
                        if (beat_q == LAST_BEAT) begin
`ifdef SEQ_LOOP_EN
                            beat_next = '0;
`else
                            state_next = DONE;
`endif
                        end else begin
                            beat_next = beat_q + BEAT_W'(1);
                        end
                    end
                end
                PAUSE: if (bus.play) state_next = PLAY;
                DONE:  state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    melody_rom #(
        .BEAT_W (BEAT_W),
        .TONE_W (TONE_W)
    ) u_melody_rom (
        .clk       (clk),
        .rst       (rst),
        .beat      (beat_q),
        .tone_code (tone_code)
    );

    assign bus.beat       = beat_q;
    assign bus.tone_code  = tone_code;
    assign bus.note_valid = note_valid_q;
`ifdef SEQ_LOOP_EN
    assign bus.done       = 1'b0;
`else
    assign bus.done       = (state == DONE);
`endif

endmodule
